// File: rtl/ili9341_frame_arbiter_if.sv
// Pixel-source bundle between frame memories, the frame arbiter and the ILI9341 controller.
interface ili9341_frame_arbiter_if #(
    parameter int PIXEL_SIZE = 16,
    parameter int ADDR_W     = 14
);
    logic [1:0]            req;
    logic [1:0]            grant;
    logic [ADDR_W-1:0]     rd_addr;
    logic [PIXEL_SIZE-1:0] rd_data0;
    logic [PIXEL_SIZE-1:0] rd_data1;
    logic                  pixel_req;
    logic [PIXEL_SIZE-1:0] pixel_out;
    logic                  pixel_valid;
    logic                  busy;
    logic                  frame_done;
    logic                  underrun;

    modport master (
        output req, rd_data0, rd_data1, pixel_req,
        input  grant, rd_addr, pixel_out, pixel_valid,
        input  busy, frame_done, underrun
    );

    modport slave (
        input  req, rd_data0, rd_data1, pixel_req,
        output grant, rd_addr, pixel_out, pixel_valid,
        output busy, frame_done, underrun
    );
endinterface

// File: rtl/ili9341_frame_arbiter.sv
// Whole-frame arbiter feeding one ILI9341 pixel stream from two synchronous pixel memories.
// Define ILI9341_ARB_FIXED_PRIO_EN to make requester 1 always win instead of round-robin.
module ili9341_frame_arbiter #(
    parameter int RESOLUTION = 128*128,
    parameter int PIXEL_SIZE = 16,
    parameter int ADDR_W     = $clog2(RESOLUTION)
) (
    input logic                    clk,
    input logic                    rst,
    ili9341_frame_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RESOLUTION - 1);

    typedef enum logic [2:0] {IDLE, ADDR, CAPT, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [PIXEL_SIZE-1:0] pix_q, pix_d;
    logic                  valid_q, valid_d;
    logic                  underrun_q, underrun_d;
    logic                  win1;
`ifndef ILI9341_ARB_FIXED_PRIO_EN
    logic                  ptr_q, ptr_d;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        pix_d      = pix_q;
        valid_d    = valid_q;
        underrun_d = underrun_q;
`ifdef ILI9341_ARB_FIXED_PRIO_EN
        win1 = bus.req[1];
`else
        ptr_d = ptr_q;
        // Pointed-to requester wins if requesting, otherwise the other one.
        win1  = ptr_q ? bus.req[1] : !bus.req[0];
`endif
        if (bus.pixel_req && (grant_q != 2'b00) && !valid_q)
            underrun_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    addr_d  = '0;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = CAPT;
            CAPT: begin
                pix_d   = grant_q[1] ? bus.rd_data1 : bus.rd_data0;
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.pixel_req && valid_q) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                grant_d = 2'b00;
                addr_d  = '0;
                state_d = IDLE;
`ifndef ILI9341_ARB_FIXED_PRIO_EN
                ptr_d   = grant_q[0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            addr_q     <= '0;
            pix_q      <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

`ifndef ILI9341_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign bus.grant       = grant_q;
    assign bus.rd_addr     = addr_q;
    assign bus.pixel_out   = pix_q;
    assign bus.pixel_valid = valid_q;
    assign bus.busy        = |grant_q;
    assign bus.frame_done  = (state_q == DONE);
    assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_ili9341_frame_arbiter.sv
// Directed bench for ili9341_frame_arbiter: 16-pixel frames, two synchronous ROM models.
module tb_ili9341_frame_arbiter;
    localparam int RES = 16;
    localparam int PW  = 16;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    ili9341_frame_arbiter_if #(.PIXEL_SIZE(PW), .ADDR_W(AW)) bus ();

    ili9341_frame_arbiter #(
        .RESOLUTION(RES),
        .PIXEL_SIZE(PW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs: source 0 holds addr+0x100, source 1 holds addr+0x200.
    always @(posedge clk) begin
        bus.rd_data0 <= 16'h0100 + 16'(bus.rd_addr);
        bus.rd_data1 <= 16'h0200 + 16'(bus.rd_addr);
    end

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".grant"}, 32'(bus.grant), 32'd0);
        check({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'd0);
        check({tag, ".pixel_out"}, 32'(bus.pixel_out), 32'd0);
        check({tag, ".pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, ".underrun"}, 32'(bus.underrun), 32'd0);
    endtask

    task automatic frame(input string tag, input logic [1:0] g,
                         input logic [15:0] base, input int npx,
                         input int glitch_at, input int drop_at);
        int n;
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < npx; i++) begin
            if (i > 0) tick(7);
            if (i == drop_at) bus.req = 2'b00;
            n = 0;
            while (bus.pixel_valid !== 1'b1 && n < 10) begin
                tick(1);
                n++;
            end
            check($sformatf("%s.valid%0d", tag, i), 32'(bus.pixel_valid), 32'd1);
            check($sformatf("%s.px%0d", tag, i), 32'(bus.pixel_out),
                  32'(base) + 32'(i));
            check($sformatf("%s.addr%0d", tag, i), 32'(bus.rd_addr), 32'(i));
            check($sformatf("%s.grant%0d", tag, i), 32'(bus.grant), 32'(g));
            bus.pixel_req = 1'b1;
            tick(1);
            bus.pixel_req = 1'b0;
            if (i == glitch_at) begin
                check($sformatf("%s.gl_valid", tag), 32'(bus.pixel_valid), 32'd0);
                bus.pixel_req = 1'b1;
                tick(1);
                bus.pixel_req = 1'b0;
                check($sformatf("%s.gl_underrun", tag), 32'(bus.underrun), 32'd1);
                check($sformatf("%s.gl_addr", tag), 32'(bus.rd_addr), 32'(i + 1));
            end
        end
        if (npx == RES) begin
            check({tag, ".done_hi"}, 32'(bus.frame_done), 32'd1);
            check({tag, ".done_grant"}, 32'(bus.grant), 32'(g));
            tick(1);
            check({tag, ".done_lo"}, 32'(bus.frame_done), 32'd0);
            check({tag, ".end_grant"}, 32'(bus.grant), 32'd0);
            check({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
            check({tag, ".end_addr"}, 32'(bus.rd_addr), 32'd0);
            check({tag, ".done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
        end
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [15:0] exp_b;
        int          d;
        bus.req       = 2'b00;
        bus.pixel_req = 1'b0;

        tick(2);
        check_reset("reset");
        rst = 1'b0;

        // Strobes while idle must be ignored.
        repeat (3) begin
            bus.pixel_req = 1'b1;
            tick(1);
            bus.pixel_req = 1'b0;
            tick(2);
        end
        check("idle.grant", 32'(bus.grant), 32'd0);
        check("idle.valid", 32'(bus.pixel_valid), 32'd0);
        check("idle.underrun", 32'(bus.underrun), 32'd0);
        check("idle.busy", 32'(bus.busy), 32'd0);

        // Single frame from source 0.
        bus.req = 2'b01;
        tick(1);
        check("f0.grant1", 32'(bus.grant), 32'd1);
        check("f0.busy", 32'(bus.busy), 32'd1);
        bus.req = 2'b00;
        frame("f0", 2'b01, 16'h0100, RES, -1, -1);
        tick(3);
        check("f0.no_regrant", 32'(bus.grant), 32'd0);
        check("f0.single_done", 32'(done_cnt), 32'd1);

        // Fresh pointer, then four back-to-back frames with both requesting.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.req = 2'b11;
        for (int f = 0; f < 4; f++) begin
`ifdef ILI9341_ARB_FIXED_PRIO_EN
            exp_g = 2'b10;
`else
            exp_g = (f % 2 == 1) ? 2'b10 : 2'b01;
`endif
            exp_b = exp_g[1] ? 16'h0200 : 16'h0100;
            tick(1);
            check($sformatf("dual%0d.grant", f), 32'(bus.grant), 32'(exp_g));
            if (f == 3) bus.req = 2'b00;
            frame($sformatf("dual%0d", f), exp_g, exp_b, RES, -1, -1);
        end

        // Early strobe while no pixel is held.
        bus.req = 2'b01;
        tick(1);
        check("ur.grant", 32'(bus.grant), 32'd1);
        bus.req = 2'b00;
        frame("ur", 2'b01, 16'h0100, RES, 3, -1);
        check("ur.sticky", 32'(bus.underrun), 32'd1);

        // Reset in the middle of a frame.
        bus.req = 2'b01;
        tick(1);
        check("rs.grant", 32'(bus.grant), 32'd1);
        bus.req = 2'b00;
        frame("rs", 2'b01, 16'h0100, 7, -1, -1);
        d = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset("rs_async");
        bus.req = 2'b10;
        tick(2);
        rst = 1'b0;
        check("rs.no_done", 32'(done_cnt), 32'(d));
        tick(1);
        check("s1.grant", 32'(bus.grant), 32'd2);
        check("s1.addr", 32'(bus.rd_addr), 32'd0);
        bus.req = 2'b00;
        frame("s1", 2'b10, 16'h0200, RES, -1, -1);

        // Request dropped mid-frame: frame still completes once.
        bus.req = 2'b01;
        tick(1);
        check("drop.grant", 32'(bus.grant), 32'd1);
        d = done_cnt;
        frame("drop", 2'b01, 16'h0100, RES, -1, 5);
        tick(4);
        check("drop.idle_grant", 32'(bus.grant), 32'd0);
        check("drop.one_done", 32'(done_cnt), 32'(d + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ili9341_frame_arbiter.md
Name: ili9341_frame_arbiter

Overview:
- Shares the single ILI9341 pixel stream between two frame sources: requester 0 (main framebuffer) and requester 1 (overlay/menu buffer).
- Grants one requester a whole frame at a time, using round-robin.
- Drives a shared read address into the granted source's synchronous pixel memory and presents one pixel at a time to the display controller on demand.
- Signals frame completion to the controller.
- Sits between the pixel ROM/RAM blocks and ili9341_controller, replacing the free-running pixel counter logic in the top level.

Parameters:
- RESOLUTION, 128*128: pixels per frame.
- PIXEL_SIZE, 16: bits per pixel (RGB565).
- ADDR_W, $clog2(RESOLUTION): pixel address width.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous reset, active-high
- req  input  2  frame request per source, level; bit i = requester i
- grant  output  2  one-hot grant; held for the full frame
- rd_addr  output  ADDR_W  shared pixel read address
- rd_data0  input  PIXEL_SIZE  pixel memory data, source 0
- rd_data1  input  PIXEL_SIZE  pixel memory data, source 1
- pixel_req  input  1  one-cycle strobe from controller (synchronised to clk) asking for next pixel
- pixel_out  output  PIXEL_SIZE  current pixel to controller
- pixel_valid  output  1  pixel_out holds an unconsumed pixel
- busy  output  1  frame in progress (grant != 0)
- frame_done  output  1  one-cycle pulse after last pixel consumed
- underrun  output  1  sticky: pixel_req seen while busy and !pixel_valid

Behaviour:
- Reset values (async, immediate):
  - grant=0, rd_addr=0, pixel_out=0, pixel_valid=0, busy=0, frame_done=0, underrun=0.
  - Priority pointer selects requester 0.
  - State IDLE.
- Memory contract: rd_data of the granted source is valid in the cycle after rd_addr changes (synchronous read, 1-cycle latency). The arbiter muxes rd_data by grant.
- IDLE:
  - If any req bit is set, pick a winner: the pointed-to requester if it is requesting, else the other one.
  - Next edge: grant=winner, rd_addr=0, busy=1, go to ADDR.
  - If no req, stay in IDLE.
- ADDR: one cycle, address presented; go to CAPT.
- CAPT: pixel_out <= selected rd_data, pixel_valid <= 1; go to STREAM.
- STREAM, pixel_req with pixel_valid=1 (consume):
  - pixel_valid <= 0.
  - If rd_addr == RESOLUTION-1: go to DONE.
  - Else rd_addr <= rd_addr+1 and go to ADDR.
  - A new pixel is valid 3 cycles after the accepted strobe. The controller's pixel_req spacing is ≥6 clk (divided SPI clock), so no stall in normal operation.
- pixel_req while busy and pixel_valid=0: ignored (no address advance) and underrun <= 1. underrun clears only on rst.
- pixel_req while IDLE: ignored; underrun not set.
- DONE: one cycle.
  - frame_done=1, grant<=0, busy<=0, rd_addr<=0.
  - Pointer moves to the other requester (the one not just served).
  - Go to IDLE. New arbitration is earliest in the IDLE cycle after DONE, so there is at least one idle cycle between frames.
- req is sampled only in IDLE. Deassertion mid-frame is ignored and the frame completes. A requester must hold req until it sees grant.
- Both requests at once: pointer wins. Continuous dual requests therefore alternate 0,1,0,1…
- Reset mid-frame: abandon the frame immediately with all reset values. No frame_done pulse.
- rd_addr never exceeds RESOLUTION-1, including non-power-of-2 RESOLUTION.

Optional Feature:
- Macro: ILI9341_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority: requester 1 (overlay) always wins a simultaneous request.
  - Pointer logic is removed.
  - A pending req1 is granted right after the current frame, even if requester 1 was just served.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then req=01 and RESOLUTION=16; source 0 ROM holds addr+0x100; pixel_req every 8 clk:
  - grant=01 within 1 cycle; pixel_out sequence 0x100..0x10F.
  - Exactly one frame_done pulse after the 16th consumption; grant=00 on the following cycle.
- req=11 held continuously for 4 frames:
  - Grants 01,10,01,10 with one-cycle frame_done between them.
  - rd_addr restarts at 0 for each frame.
  - Under ILI9341_ARB_FIXED_PRIO_EN: grant=10 every frame.
- pixel_req issued 1 cycle after a consume (pixel_valid=0):
  - rd_addr does not advance; underrun=1 and stays 1.
  - The frame still delivers all 16 pixels in order.
- rst pulsed after 7 pixels consumed:
  - All outputs return to reset values asynchronously; no frame_done.
  - After release with req=10, source 1 frame starts at rd_addr=0.
- req0 deasserted at pixel 5: grant stays 01 until all 16 pixels are consumed; a single frame_done follows.
- pixel_req strobes while IDLE with req=00: no grant, pixel_valid=0, underrun stays 0.
